// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: walks FETCH/DECODE/EXECUTE/MEM/WB and raises
// one-hot strobes per state. Illegal opcodes and memory timeouts park it in TRAP.
module multicycle_control #(
  parameter int RETIRE_W = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                branch_taken,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [2:0]          imm_sel,
  output logic                alu_src_imm,
  output logic                alu_src_pc,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Trap fires on the non-ready cycle that would push the counter to TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  logic [6:0]          opc_q, opc_d;
  logic [1:0]          cause_q, cause_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic is_r, is_load, is_store, is_branch, is_lui, is_auipc, is_jal;

  function automatic logic legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_IMM, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      OP_LOAD:  legal = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      OP_STORE: legal = (f3 inside {3'b000, 3'b001, 3'b010});
      default:  legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:         imm_of = 3'd1;
      OP_BRANCH:        imm_of = 3'd2;
      OP_LUI, OP_AUIPC: imm_of = 3'd3;
      OP_JAL:           imm_of = 3'd4;
      default:          imm_of = 3'd0;
    endcase
  endfunction

  assign is_r      = (opc_q == OP_R);
  assign is_load   = (opc_q == OP_LOAD);
  assign is_store  = (opc_q == OP_STORE);
  assign is_branch = (opc_q == OP_BRANCH);
  assign is_lui    = (opc_q == OP_LUI);
  assign is_auipc  = (opc_q == OP_AUIPC);
  assign is_jal    = (opc_q == OP_JAL);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    opc_d       = opc_q;
    cause_d     = cause_q;
    retired_d   = retired_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    imm_sel     = 3'd0;
    alu_src_imm = 1'b0;
    alu_src_pc  = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 2'd0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    trap        = 1'b0;
    trap_cause  = cause_q;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        opc_d = opcode;
        if (legal(opcode, funct3)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXECUTE: begin
        imm_sel     = imm_of(opc_q);
        alu_src_imm = !is_r;
        alu_src_pc  = is_auipc | is_jal | is_branch;
        if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken;
          state_d = S_FETCH;
        end else if (is_load | is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        imm_sel  = imm_of(opc_q);
        if (dmem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        imm_sel = imm_of(opc_q);
        pc_sel  = is_jal;
        wb_sel  = is_load ? 2'd1 : is_jal ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_TRAP;
    endcase

    if (state_d != state_q) wait_d = 8'd0;
    if (pc_we) retired_d = retired_q + RET_ONE;

    // While reset is held every output reads as its reset value.
    if (rst) begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      imm_sel     = 3'd0;
      alu_src_imm = 1'b0;
      alu_src_pc  = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 2'd0;
      pc_we       = 1'b0;
      pc_sel      = 1'b0;
      trap        = 1'b0;
      trap_cause  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      opc_q     <= 7'd0;
      cause_q   <= 2'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      opc_q     <= opc_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-instruction phase model predicts
// every strobe each cycle; a second instance with a 4-bit retire counter checks wrap.
module tb_multicycle_control;
  localparam int TIMEOUT = 15;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] imm_sel;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic       pc_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;

  logic imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, alu_src_pc, rf_we, pc_we, pc_sel, trap;
  logic [2:0] imm_sel;
  logic [1:0] wb_sel, trap_cause;
  logic [31:0] retired;
  logic s_imem_req, s_ir_we, s_dmem_req, s_dmem_we, s_alu_src_imm, s_alu_src_pc, s_rf_we, s_pc_we, s_pc_sel, s_trap;
  logic [2:0] s_imm_sel;
  logic [1:0] s_wb_sel, s_trap_cause;
  logic [3:0] s_retired;
  exp_t dut_o, dut4_o;

  multicycle_control #(.RETIRE_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .imm_sel(imm_sel), .alu_src_imm(alu_src_imm),
    .alu_src_pc(alu_src_pc), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .trap_cause(trap_cause), .retired(retired));

  multicycle_control #(.RETIRE_W(4), .TIMEOUT(TIMEOUT)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(s_imem_req), .ir_we(s_ir_we),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .imm_sel(s_imm_sel), .alu_src_imm(s_alu_src_imm),
    .alu_src_pc(s_alu_src_pc), .rf_we(s_rf_we), .wb_sel(s_wb_sel), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
    .trap(s_trap), .trap_cause(s_trap_cause), .retired(s_retired));

  assign dut_o  = {imem_req, ir_we, dmem_req, dmem_we, imm_sel, alu_src_imm, alu_src_pc,
                   rf_we, wb_sel, pc_we, pc_sel, trap, trap_cause};
  assign dut4_o = {s_imem_req, s_ir_we, s_dmem_req, s_dmem_we, s_imm_sel, s_alu_src_imm, s_alu_src_pc,
                   s_rf_we, s_wb_sel, s_pc_we, s_pc_sel, s_trap, s_trap_cause};

  always #5 clk = ~clk;

  int   n_chk = 0, n_fail = 0;
  int   exp_ret = 0;
  int   cyc_idx = 0, pcwe_idx = 0, dmem_cnt = 0;
  bit   chk_en = 1'b0;
  exp_t exp_cur = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Single compare process: every checked cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cyc_idx++;
      if (pc_we) pcwe_idx = cyc_idx;
      if (dmem_req) dmem_cnt++;
      chk("strobes", 64'(dut_o), 64'(exp_cur));
      chk("strobes_w4", 64'(dut4_o), 64'(exp_cur));
      chk("retired", 64'(retired), 64'(exp_ret));
      chk("retired_w4", 64'(s_retired), 64'(exp_ret % 16));
    end
  end

  // ---- behavioural model: expected outputs per instruction phase ----
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      OP_STORE:         return 3'd1;
      OP_BRANCH:        return 3'd2;
      OP_LUI, OP_AUIPC: return 3'd3;
      OP_JAL:           return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
    if (op inside {OP_R, OP_IMM, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL}) return 1'b1;
    if (op == OP_LOAD) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (op == OP_STORE) return f3 inside {3'd0, 3'd1, 3'd2};
    return 1'b0;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = '0;
    e.imem_req = 1'b1;
    e.ir_we = rdy;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic [6:0] op, input logic tk);
    exp_t e = '0;
    e.imm_sel = imm_of(op);
    e.alu_src_imm = (op != OP_R);
    e.alu_src_pc = op inside {OP_AUIPC, OP_JAL, OP_BRANCH};
    if (op == OP_BRANCH) begin
      e.pc_we = 1'b1;
      e.pc_sel = tk;
    end
    return e;
  endfunction

  function automatic exp_t e_mem(input logic [6:0] op, input logic rdy);
    exp_t e = '0;
    e.dmem_req = 1'b1;
    e.dmem_we = (op == OP_STORE);
    e.imm_sel = imm_of(op);
    e.pc_we = rdy && (op == OP_STORE);
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [6:0] op);
    exp_t e = '0;
    e.rf_we = 1'b1;
    e.pc_we = 1'b1;
    e.imm_sel = imm_of(op);
    e.pc_sel = (op == OP_JAL);
    e.wb_sel = (op == OP_LOAD) ? 2'd1 : (op == OP_JAL) ? 2'd2 : (op == OP_LUI) ? 2'd3 : 2'd0;
    return e;
  endfunction

  function automatic exp_t e_trap(input logic [1:0] cause);
    exp_t e = '0;
    e.trap = 1'b1;
    e.trap_cause = cause;
    return e;
  endfunction

  // One clock: publish the expectation, let the compare process sample, advance.
  task automatic cyc(input exp_t e);
    exp_cur = e;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    if (e.pc_we && !rst) exp_ret++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    chk_en = 1'b0;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    opcode = 7'($urandom);
    @(posedge clk);
    #1;
    exp_ret = 0;
    cyc('0);
    rst = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic trap_hold(input int n, input logic [1:0] cause);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      opcode = 7'($urandom);
      cyc(e_trap(cause));
    end
  endtask

  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic tk,
                          input int iw, input int dw, input int hold);
    branch_taken = 1'b0;
    dmem_ready = 1'b0;
    for (int i = 0; i < iw && i < TIMEOUT; i++) begin
      imem_ready = 1'b0;
      cyc(e_fetch(1'b0));
    end
    if (iw >= TIMEOUT) begin
      trap_hold(hold, 2'd2);
      return;
    end
    imem_ready = 1'b1;
    opcode = op;
    funct3 = f3;
    cyc(e_fetch(1'b1));
    imem_ready = 1'($urandom);
    cyc('0);
    // Opcode is latched at DECODE; scramble the live field afterwards.
    opcode = 7'h00;
    funct3 = 3'h7;
    imem_ready = 1'b0;
    if (!legal(op, f3)) begin
      trap_hold(hold, 2'd1);
      return;
    end
    branch_taken = tk;
    cyc(e_exec(op, tk));
    branch_taken = 1'b0;
    if (op == OP_BRANCH) return;
    if (op == OP_LOAD || op == OP_STORE) begin
      for (int i = 0; i < dw && i < TIMEOUT; i++) begin
        dmem_ready = 1'b0;
        cyc(e_mem(op, 1'b0));
      end
      if (dw >= TIMEOUT) begin
        trap_hold(hold, 2'd3);
        return;
      end
      dmem_ready = 1'b1;
      cyc(e_mem(op, 1'b1));
      dmem_ready = 1'b0;
      if (op == OP_STORE) return;
    end
    cyc(e_wb(op));
  endtask

  task automatic run_lat(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic tk, input int iw, input int dw, input int lat);
    int s;
    s = cyc_idx;
    do_instr(op, f3, tk, iw, dw, 0);
    chk(nm, 64'(pcwe_idx - s), 64'(lat));
  endtask

  initial begin
    int d0;
    do_reset();

    run_lat("lat_addi", OP_IMM, 3'd0, 1'b0, 0, 0, 4);
    chk("retired_after_addi", 64'(retired), 64'd1);
    d0 = dmem_cnt;
    run_lat("lat_lw_wait3", OP_LOAD, 3'd2, 1'b0, 0, 3, 8);
    chk("lw_dmem_req_cycles", 64'(dmem_cnt - d0), 64'd4);
    run_lat("lat_beq_taken", OP_BRANCH, 3'd0, 1'b1, 0, 0, 3);
    run_lat("lat_beq_not", OP_BRANCH, 3'd0, 1'b0, 0, 0, 3);
    run_lat("lat_sw", OP_STORE, 3'd2, 1'b0, 0, 0, 4);
    run_lat("lat_lw", OP_LOAD, 3'd4, 1'b0, 0, 0, 5);
    run_lat("lat_lui", OP_LUI, 3'd0, 1'b0, 0, 0, 4);
    run_lat("lat_auipc", OP_AUIPC, 3'd0, 1'b0, 2, 0, 6);
    run_lat("lat_jal", OP_JAL, 3'd0, 1'b0, 0, 0, 4);
    run_lat("lat_r", OP_R, 3'd0, 1'b0, 0, 0, 4);
    run_lat("lat_imem_wait14", OP_IMM, 3'd0, 1'b0, TIMEOUT - 1, 0, TIMEOUT + 3);
    run_lat("lat_sw_wait14", OP_STORE, 3'd0, 1'b0, 0, TIMEOUT - 1, TIMEOUT + 3);
    chk("retired_after_12", 64'(retired), 64'd12);

    // Illegal funct3 on a LOAD, then an illegal opcode.
    do_instr(OP_LOAD, 3'd3, 1'b0, 0, 0, 20);
    chk("cause_bad_f3", 64'(trap_cause), 64'd1);
    do_reset();
    do_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 20);
    chk("cause_illegal", 64'(trap_cause), 64'd1);
    chk("trap_flag", 64'(trap), 64'd1);
    do_reset();

    do_instr(OP_IMM, 3'd0, 1'b0, TIMEOUT, 0, 5);
    chk("cause_imem_to", 64'(trap_cause), 64'd2);
    do_reset();
    do_instr(OP_STORE, 3'd1, 1'b0, 0, TIMEOUT, 5);
    chk("cause_dmem_to", 64'(trap_cause), 64'd3);
    do_reset();

    // Reset in the middle of a stalled load.
    do_instr(OP_IMM, 3'd0, 1'b0, 0, 0, 0);
    imem_ready = 1'b1;
    opcode = OP_LOAD;
    funct3 = 3'd2;
    cyc(e_fetch(1'b1));
    imem_ready = 1'b0;
    cyc('0);
    cyc(e_exec(OP_LOAD, 1'b0));
    dmem_ready = 1'b0;
    cyc(e_mem(OP_LOAD, 1'b0));
    cyc(e_mem(OP_LOAD, 1'b0));
    do_reset();
    chk("retired_after_rst", 64'(retired), 64'd0);
    run_lat("lat_after_rst", OP_IMM, 3'd0, 1'b0, 0, 0, 4);

    do_reset();
    for (int i = 0; i < 17; i++) do_instr(OP_IMM, 3'd0, 1'b0, 0, 0, 0);
    chk("retired_w4_wrap", 64'(s_retired), 64'd1);
    chk("retired_17", 64'(retired), 64'd17);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
